// File: rtl/rom_token_reader.sv
// Calculator ROM reader: walks the ROM from index 0, folds digit codes into operands
// and emits NUM/OP/END/ERR tokens over valid/ready. Define SPACE_SKIP_EN to treat code 32 as whitespace.
module rom_token_reader #(
    parameter int ADDR_W = 7,
    parameter int DEPTH  = 100,
    parameter int NUM_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [ADDR_W-1:0] rom_index,
    input  logic [7:0]        rom_data,
    output logic              tok_valid,
    input  logic              tok_ready,
    output logic [1:0]        tok_kind,
    output logic [NUM_W-1:0]  tok_value,
    output logic              busy,
    output logic              done,
    output logic              error
);
    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    localparam logic [1:0]        K_NUM = 2'd0;
    localparam logic [1:0]        K_OP  = 2'd1;
    localparam logic [1:0]        K_END = 2'd2;
    localparam logic [1:0]        K_ERR = 2'd3;
    localparam int                PW    = NUM_W + 4;
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t              state, state_n;
    logic [ADDR_W-1:0]   idx_n;
    logic [NUM_W-1:0]    acc, acc_n;
    logic [7:0]          ndig, ndig_n;
    logic                past_end, past_n;
    logic                tv_n, busy_n, done_n, err_n;
    logic [1:0]          tk_n;
    logic [NUM_W-1:0]    tval_n;
    logic                ld, adv;
    logic [1:0]          ld_kind;
    logic [NUM_W-1:0]    ld_value;
    logic [PW-1:0]       prod;
    logic                ovf, is_digit, is_op, is_end, is_space;

    assign is_digit = (rom_data <= 8'd9);
    assign is_op    = (rom_data >= 8'd20) && (rom_data <= 8'd23);
    assign is_end   = (rom_data == 8'd10);
`ifdef SPACE_SKIP_EN
    assign is_space = (rom_data == 8'd32);
`else
    assign is_space = 1'b0;
`endif

    // Widened so one more decimal digit can never wrap before the range check.
    assign prod = PW'(acc) * PW'(10) + PW'(rom_data[3:0]);
    assign ovf  = |prod[PW-1:NUM_W];

    always_comb begin
        state_n  = state;
        idx_n    = rom_index;
        acc_n    = acc;
        ndig_n   = ndig;
        past_n   = past_end;
        tv_n     = tok_valid;
        tk_n     = tok_kind;
        tval_n   = tok_value;
        busy_n   = busy;
        done_n   = done;
        err_n    = error;
        ld       = 1'b0;
        adv      = 1'b0;
        ld_kind  = K_NUM;
        ld_value = '0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    idx_n   = '0;
                    acc_n   = '0;
                    ndig_n  = '0;
                    past_n  = 1'b0;
                    done_n  = 1'b0;
                    err_n   = 1'b0;
                    busy_n  = 1'b1;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (past_end || !is_digit) begin
                    if (ndig != 8'd0) begin
                        // Operand ends; the delimiter is looked at again after the transfer.
                        ld       = 1'b1;
                        ld_kind  = K_NUM;
                        ld_value = acc;
                        acc_n    = '0;
                        ndig_n   = '0;
                    end else if (past_end) begin
                        ld       = 1'b1;
                        ld_kind  = K_ERR;
                        ld_value = NUM_W'(3);
                    end else if (is_op) begin
                        ld       = 1'b1;
                        ld_kind  = K_OP;
                        ld_value = NUM_W'(rom_data - 8'd20);
                        adv      = 1'b1;
                    end else if (is_end) begin
                        ld       = 1'b1;
                        ld_kind  = K_END;
                    end else if (is_space) begin
                        adv      = 1'b1;
                    end else begin
                        ld       = 1'b1;
                        ld_kind  = K_ERR;
                        ld_value = NUM_W'(1);
                    end
                end else if (ovf) begin
                    ld       = 1'b1;
                    ld_kind  = K_ERR;
                    ld_value = NUM_W'(2);
                end else begin
                    acc_n  = prod[NUM_W-1:0];
                    ndig_n = (ndig == 8'hff) ? ndig : ndig + 8'd1;
                    adv    = 1'b1;
                end
            end
            EMIT: begin
                if (tok_valid && tok_ready) begin
                    tv_n = 1'b0;
                    if (tok_kind == K_END || tok_kind == K_ERR) begin
                        state_n = DONE;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        err_n   = (tok_kind == K_ERR);
                    end else begin
                        state_n = SCAN;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        // Stepping off the last entry is remembered rather than wrapping the index.
        if (adv) begin
            if (rom_index == LAST) past_n = 1'b1;
            else                   idx_n  = rom_index + 1'b1;
        end
        if (ld) begin
            tv_n    = 1'b1;
            tk_n    = ld_kind;
            tval_n  = ld_value;
            state_n = EMIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rom_index <= '0;
            acc       <= '0;
            ndig      <= '0;
            past_end  <= 1'b0;
            tok_valid <= 1'b0;
            tok_kind  <= K_NUM;
            tok_value <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            state     <= state_n;
            rom_index <= idx_n;
            acc       <= acc_n;
            ndig      <= ndig_n;
            past_end  <= past_n;
            tok_valid <= tv_n;
            tok_kind  <= tk_n;
            tok_value <= tval_n;
            busy      <= busy_n;
            done      <= done_n;
            error     <= err_n;
        end
    end
endmodule

// File: tb/tb_rom_token_reader.sv
// Bench for rom_token_reader: a plain parser over the ROM array predicts the token stream,
// one negedge process checks every transfer and stall; directed tests cover the boundaries.
module tb_rom_token_reader;
    localparam int ADDR_W = 7;
    localparam int DEPTH  = 100;
`ifdef SPACE_SKIP_EN
    localparam bit SPACE_EN = 1'b1;
`else
    localparam bit SPACE_EN = 1'b0;
`endif

    typedef struct {
        int     kind;
        longint value;
    } tok_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic              tok_ready = 1'b1;
    logic [ADDR_W-1:0] rom_index;
    logic [7:0]        rom_data;
    logic              tok_valid, busy, done, error;
    logic [1:0]        tok_kind;
    logic [15:0]       tok_value;

    logic              start8 = 1'b0;
    logic              ready8 = 1'b1;
    logic [ADDR_W-1:0] rom_index8;
    logic [7:0]        rom_data8;
    logic              tok_valid8, busy8, done8, error8;
    logic [1:0]        tok_kind8;
    logic [7:0]        tok_value8;

    logic [7:0] rom  [128];
    logic [7:0] rom8 [128];
    assign rom_data  = rom[rom_index];
    assign rom_data8 = rom8[rom_index8];

    int   n_chk = 0, n_fail = 0, n_xfer = 0, wcnt = 0;
    bit   chk_en = 1'b0, stall = 1'b0, held_v = 1'b0;
    int   held_k;
    longint held_val;
    tok_t exp_q[$];

    always #5 clk = ~clk;

    rom_token_reader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_index(rom_index), .rom_data(rom_data),
        .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_kind(tok_kind),
        .tok_value(tok_value), .busy(busy), .done(done), .error(error));

    rom_token_reader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_W(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .rom_index(rom_index8), .rom_data(rom_data8),
        .tok_valid(tok_valid8), .tok_ready(ready8), .tok_kind(tok_kind8),
        .tok_value(tok_value8), .busy(busy8), .done(done8), .error(error8));

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int k, input longint v);
        tok_t t;
        t.kind  = k;
        t.value = v;
        exp_q.push_back(t);
    endtask

    // Reference parser: reads the ROM as text, not as a state machine.
    task automatic build_model(input int numw);
        int     i = 0;
        bit     fin = 1'b0;
        longint v;
        longint mx = (longint'(1) << numw) - 1;
        exp_q.delete();
        while (!fin) begin
            if (i >= DEPTH) begin
                push(3, 3); fin = 1'b1;
            end else if (rom[i] <= 9) begin
                v = 0;
                while (!fin && i < DEPTH && rom[i] <= 9) begin
                    v = v * 10 + longint'(rom[i]);
                    if (v > mx) begin push(3, 2); fin = 1'b1; end
                    else i++;
                end
                if (!fin) push(0, v);
            end else if (rom[i] >= 20 && rom[i] <= 23) begin
                push(1, longint'(rom[i]) - 20); i++;
            end else if (rom[i] == 10) begin
                push(2, 0); fin = 1'b1;
            end else if (SPACE_EN && rom[i] == 32) begin
                i++;
            end else begin
                push(3, 1); fin = 1'b1;
            end
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 128; i++) rom[i] = v;
    endtask

    task automatic load_rom1();
        fill(8'd0);
        rom[0] = 5; rom[1] = 5; rom[2] = 20; rom[3] = 1; rom[4] = 1; rom[5] = 10;
    endtask

    // Stalling consumer: hold ready low for 3 cycles of every token.
    always @(posedge clk) begin
        #2;
        if (!stall) tok_ready = 1'b1;
        else if (!tok_valid) begin tok_ready = 1'b0; wcnt = 0; end
        else if (wcnt < 3) begin tok_ready = 1'b0; wcnt++; end
        else tok_ready = 1'b1;
    end

    always @(negedge clk) begin
        tok_t e;
        if (!chk_en) held_v = 1'b0;
        else if (tok_valid) begin
            if (held_v) begin
                chk("hold_kind", tok_kind, held_k);
                chk("hold_value", tok_value, held_val);
            end
            if (tok_ready) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL extra_token: got kind %0d value %0d, none expected", tok_kind, tok_value);
                end else begin
                    e = exp_q.pop_front();
                    chk("tok_kind", tok_kind, e.kind);
                    chk("tok_value", tok_value, e.value);
                end
                n_xfer++;
                held_v = 1'b0;
            end else begin
                held_v   = 1'b1;
                held_k   = tok_kind;
                held_val = tok_value;
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic run_scan(input string nm, input bit st);
        bit got = 1'b0;
        bit exp_err;
        build_model(16);
        exp_err = (exp_q[exp_q.size()-1].kind == 3);
        stall  = st;
        n_xfer = 0;
        chk_en = 1'b1;
        pulse_start();
        chk({nm, "_busy"}, busy, 1);
        for (int c = 0; c < 3000 && !got; c++) begin
            @(negedge clk);
            got = done;
        end
        if (!got) begin
            n_chk++; n_fail++;
            $display("FAIL %s_timeout: done not seen within 3000 cycles", nm);
        end
        chk({nm, "_left"}, exp_q.size(), 0);
        chk({nm, "_done"}, done, 1);
        chk({nm, "_idle"}, busy, 0);
        chk({nm, "_error"}, error, exp_err);
        chk_en = 1'b0;
        stall  = 1'b0;
    endtask

    initial begin
        bit got;
        for (int i = 0; i < 128; i++) rom8[i] = 8'd0;
        load_rom1();
        #1;
        chk("rst_index", rom_index, 0);
        chk("rst_valid", tok_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Pin the model with the hand-derived stream for 5 5 + 1 1 #.
        build_model(16);
        chk("model_len", exp_q.size(), 4);
        chk("model_num55", exp_q[0].value, 55);
        chk("model_op", exp_q[1].kind, 1);
        chk("model_num11", exp_q[2].value, 11);
        chk("model_end", exp_q[3].kind, 2);

        run_scan("basic", 1'b0);
        chk("basic_index", rom_index, 5);
        chk("basic_ntok", n_xfer, 4);
        run_scan("stall", 1'b1);
        chk("stall_ntok", n_xfer, 4);

        fill(8'd0);
        rom[0] = 7; rom[1] = 99; rom[2] = 10;
        run_scan("illegal", 1'b0);
        chk("illegal_err", error, 1);
        chk("illegal_val", tok_value, 1);

        fill(8'd20);
        run_scan("noterm", 1'b0);
        chk("noterm_ntok", n_xfer, 101);
        chk("noterm_val", tok_value, 3);

        fill(8'd20);
        rom[98] = 4; rom[99] = 5;
        run_scan("lastdig", 1'b0);
        chk("lastdig_val", tok_value, 3);

        // Abort with a token pending, then rescan.
        load_rom1();
        stall = 1'b1;
        pulse_start();
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = tok_valid;
        end
        chk("abort_pending", got, 1);
        stall = 1'b0;
        rst   = 1'b1;
        #1;
        chk("abort_valid", tok_valid, 0);
        chk("abort_index", rom_index, 0);
        chk("abort_busy", busy, 0);
        chk("abort_kind", tok_kind, 0);
        chk("abort_value", tok_value, 0);
        @(negedge clk) rst = 1'b0;
        run_scan("rescan", 1'b0);
        chk("rescan_index", rom_index, 5);

        fill(8'd0);
        rom[0] = 1; rom[1] = 32; rom[2] = 32; rom[3] = 2; rom[4] = 10;
        build_model(16);
        chk("space_model_len", exp_q.size(), SPACE_EN ? 3 : 2);
        run_scan("space", 1'b0);

        // Narrow operand: 25*10+6 overflows 8 bits before any NUM is produced.
        rom8[0] = 2; rom8[1] = 5; rom8[2] = 6; rom8[3] = 10;
        @(negedge clk) start8 = 1'b1;
        @(negedge clk) start8 = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 50 && !got; c++) begin
            @(negedge clk);
            got = tok_valid8;
        end
        chk("ovf_seen", got, 1);
        chk("ovf_kind", tok_kind8, 3);
        chk("ovf_value", tok_value8, 2);
        chk("ovf_index", rom_index8, 2);
        @(negedge clk);
        chk("ovf_done", done8, 1);
        chk("ovf_error", error8, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
